// File: rtl/echo_request_arbiter.sv
// rtl/echo_request_arbiter.sv - two-port round-robin echo arbiter over a shared FIFO
// Responses return in issue order; a tag queue remembers which requester owns each entry.
module echo_request_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0_enq__ENA,
   input  logic [WIDTH-1:0] req0_enq_v,
   output logic             req0_enq__RDY,
   input  logic             req1_enq__ENA,
   input  logic [WIDTH-1:0] req1_enq_v,
   output logic             req1_enq__RDY,
   output logic             fifo_enq__ENA,
   output logic [WIDTH-1:0] fifo_enq_v,
   input  logic             fifo_enq__RDY,
   input  logic [WIDTH-1:0] fifo_first,
   input  logic             fifo_first__RDY,
   output logic             fifo_deq__ENA,
   input  logic             fifo_deq__RDY,
   output logic             ind0_echo__ENA,
   output logic [WIDTH-1:0] ind0_echo_v,
   input  logic             ind0_echo__RDY,
   output logic             ind1_echo__ENA,
   output logic [WIDTH-1:0] ind1_echo_v,
   input  logic             ind1_echo__RDY,
   output logic [15:0]      echo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic             buf0_valid, buf1_valid;
   logic [WIDTH-1:0] buf0_data, buf1_data;
   logic             last_grant;
   logic [DEPTH-1:0] tag_q;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    tag_count;
   logic             grant, issue, head_tag, tag_ready, respond;

   always_comb begin
      grant     = (buf0_valid && buf1_valid) ? ~last_grant : buf1_valid;
      // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot early.
      issue     = !RST && fifo_enq__RDY && (tag_count < CW'(DEPTH)) && (buf0_valid || buf1_valid);
      head_tag  = tag_q[rd_ptr];
      tag_ready = head_tag ? ind1_echo__RDY : ind0_echo__RDY;
      respond   = !RST && (tag_count != '0) && fifo_first__RDY && fifo_deq__RDY && tag_ready;
   end

   assign req0_enq__RDY  = !RST && !buf0_valid;
   assign req1_enq__RDY  = !RST && !buf1_valid;
   assign fifo_enq__ENA  = issue;
   assign fifo_enq_v     = grant ? buf1_data : buf0_data;
   assign fifo_deq__ENA  = respond;
   assign ind0_echo__ENA = respond && !head_tag;
   assign ind1_echo__ENA = respond && head_tag;
   assign ind0_echo_v    = fifo_first;
   assign ind1_echo_v    = fifo_first;

   always_ff @(posedge CLK) begin
      if (RST) begin
         buf0_valid <= 1'b0;
         buf1_valid <= 1'b0;
         buf0_data  <= '0;
         buf1_data  <= '0;
         last_grant <= 1'b1;
         tag_q      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         tag_count  <= '0;
         echo_count <= '0;
      end else begin
         // A buffer is only loadable while empty, so it cannot refill in its drain cycle.
         if (req0_enq__ENA && !buf0_valid) begin
            buf0_valid <= 1'b1;
            buf0_data  <= req0_enq_v;
         end else if (issue && !grant) begin
            buf0_valid <= 1'b0;
         end
         if (req1_enq__ENA && !buf1_valid) begin
            buf1_valid <= 1'b1;
            buf1_data  <= req1_enq_v;
         end else if (issue && grant) begin
            buf1_valid <= 1'b0;
         end
         if (issue) begin
            last_grant    <= grant;
            tag_q[wr_ptr] <= grant;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (respond) begin
            rd_ptr     <= rd_ptr + PW'(1);
            echo_count <= echo_count + 16'd1;
         end
         case ({issue, respond})
            2'b10:   tag_count <= tag_count + CW'(1);
            2'b01:   tag_count <= tag_count - CW'(1);
            default: tag_count <= tag_count;
         endcase
      end
   end
endmodule

// File: tb/tb_echo_request_arbiter.sv
// tb/tb_echo_request_arbiter.sv - scoreboard bench for echo_request_arbiter
// Directed stimulus pushes hand-computed issue/indication expectations; negedge monitors pop them.
module tb_echo_request_arbiter;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req0_enq__ENA = 1'b0, req1_enq__ENA = 1'b0;
   logic [31:0] req0_enq_v = '0, req1_enq_v = '0;
   logic        req0_enq__RDY, req1_enq__RDY;
   logic        fifo_enq__ENA, fifo_deq__ENA;
   logic [31:0] fifo_enq_v, fifo_first;
   logic        fifo_enq__RDY = 1'b1, fifo_deq__RDY = 1'b1;
   logic        fifo_first__RDY;
   logic        ind0_echo__ENA, ind1_echo__ENA;
   logic [31:0] ind0_echo_v, ind1_echo_v;
   logic        ind0_echo__RDY = 1'b1, ind1_echo__RDY = 1'b1;
   logic [15:0] echo_count;

   logic        first_en = 1'b1;
   logic [31:0] env_mem [0:63];
   logic [5:0]  env_head = '0, env_tail = '0;

   logic [31:0] q0[$], q1[$], exp_issue[$], exp_ind[$];
   int checks = 0, failures = 0;
   int issue_cnt = 0, ind_cnt0 = 0, ind_cnt1 = 0;

   echo_request_arbiter #(.WIDTH(32), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .req0_enq__ENA(req0_enq__ENA), .req0_enq_v(req0_enq_v), .req0_enq__RDY(req0_enq__RDY),
      .req1_enq__ENA(req1_enq__ENA), .req1_enq_v(req1_enq_v), .req1_enq__RDY(req1_enq__RDY),
      .fifo_enq__ENA(fifo_enq__ENA), .fifo_enq_v(fifo_enq_v), .fifo_enq__RDY(fifo_enq__RDY),
      .fifo_first(fifo_first), .fifo_first__RDY(fifo_first__RDY),
      .fifo_deq__ENA(fifo_deq__ENA), .fifo_deq__RDY(fifo_deq__RDY),
      .ind0_echo__ENA(ind0_echo__ENA), .ind0_echo_v(ind0_echo_v), .ind0_echo__RDY(ind0_echo__RDY),
      .ind1_echo__ENA(ind1_echo__ENA), .ind1_echo_v(ind1_echo_v), .ind1_echo__RDY(ind1_echo__RDY),
      .echo_count(echo_count)
   );

   always #5 CLK = ~CLK;

   // Shared echo FIFO environment model
   assign fifo_first      = env_mem[env_head];
   assign fifo_first__RDY = (env_head != env_tail) && first_en;
   always @(posedge CLK) begin
      if (RST) begin
         env_head <= '0;
         env_tail <= '0;
      end else begin
         if (fifo_enq__ENA) begin
            env_mem[env_tail] <= fifo_enq_v;
            env_tail <= env_tail + 6'd1;
         end
         if (fifo_deq__ENA) env_head <= env_head + 6'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Requester drivers: present the next queued value whenever the port is ready
   initial forever begin
      @(posedge CLK); #1;
      if (q0.size() > 0 && req0_enq__RDY) begin
         req0_enq__ENA = 1'b1; req0_enq_v = q0.pop_front();
      end else req0_enq__ENA = 1'b0;
   end
   initial forever begin
      @(posedge CLK); #1;
      if (q1.size() > 0 && req1_enq__RDY) begin
         req1_enq__ENA = 1'b1; req1_enq_v = q1.pop_front();
      end else req1_enq__ENA = 1'b0;
   end

   // Issue monitor
   always @(negedge CLK) begin
      if (fifo_enq__ENA) begin
         issue_cnt++;
         if (exp_issue.size() == 0) check("unexpected_issue", fifo_enq_v, 32'hFFFF_FFFF);
         else check("issue_data", fifo_enq_v, exp_issue.pop_front());
      end
   end

   // Indication monitor; expected entries encode port in bit 31
   always @(negedge CLK) begin
      if (ind0_echo__ENA && ind1_echo__ENA) check("both_ind_ena", 32'd1, 32'd0);
      if (fifo_deq__ENA !== (ind0_echo__ENA || ind1_echo__ENA))
         check("deq_vs_ind", {31'd0, fifo_deq__ENA}, {31'd0, ind0_echo__ENA || ind1_echo__ENA});
      if (ind0_echo__ENA || ind1_echo__ENA) begin
         logic [31:0] got;
         got = ind1_echo__ENA ? {1'b1, ind1_echo_v[30:0]} : {1'b0, ind0_echo_v[30:0]};
         if (ind1_echo__ENA) ind_cnt1++; else ind_cnt0++;
         if (exp_ind.size() == 0) check("unexpected_ind", got, 32'hFFFF_FFFF);
         else check("ind_port_data", got, exp_ind.pop_front());
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_issue.size() + exp_ind.size() + q0.size() + q1.size()) != 0 && n < 300) begin
         @(posedge CLK); n++;
      end
      cycles(3);
      check(name, {31'd0, n < 300}, 32'd1);
   endtask

   task automatic expect_echo(input logic port, input logic [31:0] v);
      exp_issue.push_back(v);
      exp_ind.push_back({port, v[30:0]});
   endtask

   initial begin
      // Reset state
      cycles(3);
      @(negedge CLK);
      check("rst_fifo_enq_ena", {31'd0, fifo_enq__ENA}, 32'd0);
      check("rst_fifo_deq_ena", {31'd0, fifo_deq__ENA}, 32'd0);
      check("rst_ind_ena", {30'd0, ind1_echo__ENA, ind0_echo__ENA}, 32'd0);
      check("rst_req_rdy", {30'd0, req1_enq__RDY, req0_enq__RDY}, 32'd0);
      check("rst_echo_count", {16'd0, echo_count}, 32'd0);
      @(posedge CLK); #2; RST = 1'b0;
      cycles(2);
      check("idle_req_rdy", {30'd0, req1_enq__RDY, req0_enq__RDY}, 32'd3);

      // Tie right after reset: port 0 first
      expect_echo(1'b0, 32'd5); expect_echo(1'b1, 32'd7);
      q0.push_back(32'd5); q1.push_back(32'd7);
      drain("tie_drain");

      // Single echo with one-cycle issue latency
      expect_echo(1'b0, 32'd22);
      q0.push_back(32'd22);
      @(posedge CLK); @(posedge CLK); @(negedge CLK);
      check("single_latency_ena", {31'd0, fifo_enq__ENA}, 32'd1);
      check("single_latency_v", fifo_enq_v, 32'd22);
      drain("single_drain");
      check("echo_count_3", {16'd0, echo_count}, 32'd3);

      // Reset with two tags outstanding (last grant was port 0, so port 1 wins this tie)
      first_en = 1'b0;
      exp_issue.push_back(32'h31); exp_issue.push_back(32'h30);
      q0.push_back(32'h30); q1.push_back(32'h31);
      drain("pre_reset_drain");
      check("pre_reset_count", {16'd0, echo_count}, 32'd3);
      RST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      check("midrst_enas", {28'd0, fifo_enq__ENA, fifo_deq__ENA, ind0_echo__ENA, ind1_echo__ENA}, 32'd0);
      check("midrst_rdys", {30'd0, req1_enq__RDY, req0_enq__RDY}, 32'd0);
      check("midrst_echo_count", {16'd0, echo_count}, 32'd0);
      @(posedge CLK); #2; RST = 1'b0; first_en = 1'b1;
      cycles(4);
      check("post_rst_no_ind", {16'd0, echo_count}, 32'd0);

      // Fairness: continuous demand alternates 0,1,0,1
      ind_cnt0 = 0; ind_cnt1 = 0;
      for (int k = 0; k < 4; k++) begin
         expect_echo(1'b0, 32'h100 + k);
         expect_echo(1'b1, 32'h200 + k);
         q0.push_back(32'h100 + k); q1.push_back(32'h200 + k);
      end
      drain("fair_drain");
      check("fair_port0", ind_cnt0, 32'd4);
      check("fair_port1", ind_cnt1, 32'd4);
      check("echo_count_8", {16'd0, echo_count}, 32'd8);

      // Tag queue full: FIFO head withheld
      first_en = 1'b0; issue_cnt = 0; ind_cnt0 = 0; ind_cnt1 = 0;
      for (int k = 0; k < 3; k++) begin
         expect_echo(1'b0, 32'h40 + k);
         expect_echo(1'b1, 32'h50 + k);
         q0.push_back(32'h40 + k); q1.push_back(32'h50 + k);
      end
      cycles(12);
      check("full_issue_cnt", issue_cnt, 32'd4);
      check("full_req_rdy", {30'd0, req1_enq__RDY, req0_enq__RDY}, 32'd0);
      first_en = 1'b1;
      drain("full_drain");
      check("full_issue_total", issue_cnt, 32'd6);
      check("full_ind_total", ind_cnt0 + ind_cnt1, 32'd6);

      // Indication backpressure: head tag 1 blocked, tag 0 waits behind it
      first_en = 1'b0;
      expect_echo(1'b1, 32'h61);
      q1.push_back(32'h61);
      cycles(4);
      expect_echo(1'b0, 32'h60);
      q0.push_back(32'h60);
      cycles(4);
      ind1_echo__RDY = 1'b0; first_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("bp_no_deq", {31'd0, fifo_deq__ENA}, 32'd0);
         check("bp_no_ind0", {31'd0, ind0_echo__ENA}, 32'd0);
      end
      @(posedge CLK); #2; ind1_echo__RDY = 1'b1;
      drain("bp_drain");
      check("echo_count_16", {16'd0, echo_count}, 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end
endmodule

// File: doc/echo_request_arbiter.md
ECHO_REQUEST_ARBITER -- requirements
Module: echo_request_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data width; DEPTH, default 4, tag-queue entries (power of 2, >=2).
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 req0_enq__ENA  input  1 / req0_enq_v  input  WIDTH / req0_enq__RDY  output  1: requester 0 enqueue method.
REQ-005 req1_enq__ENA  input  1 / req1_enq_v  input  WIDTH / req1_enq__RDY  output  1: requester 1 enqueue method.
REQ-006 fifo_enq__ENA  output  1 / fifo_enq_v  output  WIDTH / fifo_enq__RDY  input  1: shared echo FIFO enqueue.
REQ-007 fifo_first  input  WIDTH / fifo_first__RDY  input  1 / fifo_deq__ENA  output  1 / fifo_deq__RDY  input  1: shared echo FIFO head and dequeue.
REQ-008 ind0_echo__ENA  output  1 / ind0_echo_v  output  WIDTH / ind0_echo__RDY  input  1: indication to requester 0.
REQ-009 ind1_echo__ENA  output  1 / ind1_echo_v  output  WIDTH / ind1_echo__RDY  input  1: indication to requester 1.
REQ-010 echo_count  output  16  number of indications delivered, registered.

Function
REQ-011 Each requester port SHALL own a 1-entry input buffer (valid bit + WIDTH data); reqN_enq__RDY SHALL equal NOT bufN_valid, independent of any ENA.
REQ-012 reqN_enq__ENA with RDY high SHALL load reqN_enq_v into bufN and set bufN_valid on the next edge; ENA while RDY low is a protocol error, ignored.
REQ-013 A buffer SHALL NOT be reloaded in the cycle it drains; earliest refill is the cycle after drain.
REQ-014 Issue condition: fifo_enq__RDY=1 AND tag_count<DEPTH AND at least one bufN_valid; else fifo_enq__ENA=0.
REQ-015 Grant: if only one buffer valid, grant it; if both valid, grant the port not equal to last_grant (round-robin).
REQ-016 On issue: fifo_enq__ENA=1 and fifo_enq_v=bufG data combinationally in the same cycle; next edge clears bufG_valid, sets last_grant=G, pushes tag G into the tag queue.
REQ-017 Latency: ENA at cycle N -> fifo_enq__ENA earliest at cycle N+1.
REQ-018 Tag queue: DEPTH x 1-bit circular FIFO with wrap-around read/write pointers and count 0..DEPTH; tag_count<DEPTH is evaluated on the pre-edge count, so a full queue blocks issue even if a pop occurs that cycle.
REQ-019 Respond condition: tag_count>0 AND fifo_first__RDY AND fifo_deq__RDY AND indT_echo__RDY, where T is the head tag.
REQ-020 On respond (same cycle, combinational): fifo_deq__ENA=1, indT_echo__ENA=1, indT_echo_v=fifo_first; the other indication ENA stays 0; next edge pops the tag and increments echo_count.
REQ-021 If indT_echo__RDY=0, the response SHALL stall (no deq, no ENA) without reordering; the other requester's responses wait behind it (in-order).
REQ-022 Simultaneous issue and respond in one cycle SHALL both take effect; tag_count unchanged.
REQ-023 echo_count SHALL wrap 0xFFFF -> 0x0000.
REQ-024 indN_echo_v SHALL equal fifo_first whenever indN_echo__ENA=1; value otherwise is don't-care.

Reset
REQ-025 While RST=1 at an edge: buf0/buf1 valid=0, last_grant=1 (port 0 wins first tie), tag pointers and count=0, echo_count=0.
REQ-026 While RST=1, all ENA outputs and reqN_enq__RDY SHALL be driven 0; reset mid-transfer discards buffered data and outstanding tags without emitting indications.

Verification
REQ-027 Single echo: req0 enq v=22, FIFO always ready -> fifo_enq_v=22 at N+1; deq -> ind0_echo_v=22, ind1 silent, echo_count=1.
REQ-028 Tie: both ports enq in same cycle (0:5, 1:7) -> issue order 5 then 7; indications ind0=5 then ind1=7, in order.
REQ-029 Fairness: both ports enq continuously for 8 issues -> grants alternate 0,1,0,1...; per-port count 4 each.
REQ-030 Tag full: DEPTH=4, fifo_first__RDY held 0, 6 enqs -> exactly 4 fifo issues, req RDYs go low; release -> remaining 2 issue, 6 indications total.
REQ-031 Indication backpressure: head tag 1, ind1_echo__RDY=0 for 3 cycles -> no fifo_deq__ENA, no ind0 ENA despite pending tag-0 entry behind; release -> ind1 then ind0.
REQ-032 Reset mid-operation: assert RST with 2 tags outstanding -> next cycle all ENA/RDY 0, echo_count=0; after release first tie grants port 0.
